fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be:
  - NUM_REQ, default 4: number of requester channels.
  - DATA_WIDTH, default 64: width of one data beat.
  - BURST_LEN, default 16: maximum beats per grant.
  - ID_W = clog2(NUM_REQ): derived, not overridable.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Ports SHALL be:
  - wr_clk  in  1  clock; all logic on rising edge.
  - global_rst  in  1  asynchronous active-high reset.
  - req_valid  in  NUM_REQ  per-channel beat valid.
  - req_data  in  NUM_REQ*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH].
  - req_ready  out  NUM_REQ  per-channel beat accept.
  - fifo_full  in  1  FIFO write-side full.
  - fifo_prog_full  in  1  FIFO programmable-full.
  - fifo_wr_en  out  1  FIFO write strobe.
  - fifo_din  out  DATA_WIDTH  FIFO write data.
  - grant_vld  out  1  a burst grant is active.
  - grant_id  out  ID_W  granted channel index.
  - burst_done  out  1  one-cycle pulse at burst end.

Function
REQ-004 The FSM SHALL have exactly two states, IDLE and BURST, held in a register.
REQ-005 In IDLE with fifo_prog_full=0 and any req_valid=1, the arbiter SHALL select the first valid channel searching round-robin from rr_ptr upward, wrapping at NUM_REQ-1 to 0.
REQ-006 On that selection, the next edge SHALL load grant_id, clear beat_cnt and enter BURST.
REQ-007 In IDLE with fifo_prog_full=1, the arbiter SHALL remain in IDLE and grant nothing.
REQ-008 In BURST, req_ready[grant_id] SHALL equal ~fifo_full (combinational); all other req_ready bits SHALL be 0.
REQ-009 In IDLE, req_ready SHALL be all zeros.
REQ-010 fifo_wr_en SHALL equal (state==BURST) & req_valid[grant_id] & ~fifo_full (combinational).
REQ-011 fifo_din SHALL equal the req_data slice selected by grant_id (combinational), in every state.
REQ-012 Each accepted beat (fifo_wr_en=1) SHALL increment beat_cnt; beat_cnt SHALL hold while fifo_full=1.
REQ-013 The burst SHALL end on either of two conditions:
  - a beat is accepted with beat_cnt==BURST_LEN-1;
  - req_valid[grant_id]=0 in any BURST cycle, including the first (zero-beat burst).
REQ-014 At burst end, the next edge SHALL return to IDLE, set rr_ptr to (grant_id+1) mod NUM_REQ, and assert burst_done (registered) for exactly one cycle.
REQ-015 IDLE SHALL last at least one cycle between consecutive bursts.
REQ-016 fifo_full in BURST SHALL stall without ending the burst; the grant SHALL be held indefinitely.
REQ-017 fifo_prog_full rising during BURST SHALL NOT truncate the burst; it gates only new grants.
REQ-018 grant_vld SHALL equal (state==BURST); grant_id SHALL hold its last value while in IDLE.
REQ-019 The beat_cnt width SHALL be clog2(BURST_LEN+1), and beat_cnt SHALL never exceed BURST_LEN.

Reset
REQ-020 global_rst=1 SHALL immediately (asynchronously) force:
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, burst_done=0;
  - hence grant_vld=0, req_ready=0, fifo_wr_en=0.
REQ-021 Reset asserted mid-burst SHALL abort the burst with no further writes; after release, arbitration SHALL restart from channel 0.

Verification (NUM_REQ=4, DATA_WIDTH=64, BURST_LEN=4)
REQ-022 Reset check: hold global_rst 3 cycles with all req_valid=1 -> fifo_wr_en, req_ready, grant_vld and burst_done all 0 throughout.
REQ-023 Single channel: ch2 always valid, data 0x100 incrementing per accepted beat, FIFO never full -> repeating pattern:
  - 4 writes 0x100..0x103 with grant_id=2;
  - burst_done pulse, 1 IDLE cycle;
  - next burst writes 0x104..0x107.
REQ-024 Fairness: all four channels always valid -> grant_id sequence 0,1,2,3,0, each burst exactly 4 fifo_wr_en pulses.
REQ-025 Backpressure:
  - fifo_full=1 for 3 cycles after the 2nd beat of ch0 -> fifo_wr_en=0 and req_ready[0]=0 for those 3 cycles;
  - burst then completes with exactly 4 total beats, data order preserved.
REQ-026 Early end / prog_full:
  - ch0 drops valid after 2 beats -> burst_done next cycle, next grant_id=1 when ch1 valid;
  - fifo_prog_full=1 in IDLE with ch3 valid -> no grant until prog_full falls, then grant_id=3 after one edge.
REQ-027 Reset mid-burst: global_rst pulsed during beat 2 of ch1 -> fifo_wr_en=0 immediately; after release with all channels valid, first grant_id=0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle shared by the write arbiter: requester channels, FIFO write port and grant status.
// The master view belongs to the arbiter; the slave view belongs to the requesters plus FIFO.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_prog_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic                          grant_vld;
  logic [ID_W-1:0]               grant_id;
  logic                          burst_done;

  modport master (
    input  req_valid, req_data, fifo_full, fifo_prog_full,
    output req_ready, fifo_wr_en, fifo_din, grant_vld, grant_id, burst_done
  );

  modport slave (
    output req_valid, req_data, fifo_full, fifo_prog_full,
    input  req_ready, fifo_wr_en, fifo_din, grant_vld, grant_id, burst_done
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that funnels NUM_REQ requester channels into one FIFO
// write port. A grant lasts up to BURST_LEN accepted beats or until the granted
// channel drops valid; at least one IDLE cycle separates consecutive bursts.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 16
) (
  input  logic                 wr_clk,
  input  logic                 global_rst,
  fifo_wr_arbiter_if.master    bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state_r;
  logic [ID_W-1:0] rr_ptr_r;
  logic [ID_W-1:0] grant_id_r;
  logic [CNT_W-1:0] beat_cnt_r;
  logic            burst_done_r;

  logic            sel_found_s;
  logic [ID_W-1:0] sel_id_s;
  logic [ID_W:0]   rr_sum_s;
  logic [ID_W-1:0] rr_idx_s;
  logic            cur_valid_s;
  logic            wr_en_s;
  logic            last_beat_s;
  logic            burst_end_s;
  logic [ID_W-1:0] next_ptr_s;
  logic [NUM_REQ-1:0]    ready_s;
  logic [DATA_WIDTH-1:0] din_s;

  // Round-robin search: first valid channel at or after rr_ptr, wrapping to 0.
  always_comb begin
    sel_found_s = 1'b0;
    sel_id_s    = rr_ptr_r;
    rr_sum_s    = '0;
    rr_idx_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_sum_s = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
      if (rr_sum_s >= (ID_W+1)'(NUM_REQ)) begin
        rr_sum_s = rr_sum_s - (ID_W+1)'(NUM_REQ);
      end else begin
        rr_sum_s = rr_sum_s;
      end
      rr_idx_s = rr_sum_s[ID_W-1:0];
      if (!sel_found_s && bus.req_valid[rr_idx_s]) begin
        sel_found_s = 1'b1;
        sel_id_s    = rr_idx_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Write-side qualifiers for the granted channel and the two burst-end conditions.
  always_comb begin
    cur_valid_s = bus.req_valid[grant_id_r];
    wr_en_s     = (state_r == BURST) && cur_valid_s && !bus.fifo_full;
    last_beat_s = wr_en_s && (beat_cnt_r == CNT_W'(BURST_LEN - 1));
    burst_end_s = (state_r == BURST) && (!cur_valid_s || last_beat_s);
    if (grant_id_r == ID_W'(NUM_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_id_r + ID_W'(1);
    end
  end

  // Only the granted channel sees ready, and only while the FIFO has room.
  always_comb begin
    ready_s = '0;
    if (state_r == BURST) begin
      ready_s[grant_id_r] = !bus.fifo_full;
    end else begin
      ready_s = '0;
    end
  end

  // Data mux follows grant_id in every state so fifo_din is never undefined.
  always_comb begin
    din_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_r == ID_W'(i)) begin
        din_s = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        din_s = din_s;
      end
    end
  end

  // Arbitration FSM: grant selection, beat counting, burst end and round-robin update.
  always_ff @(posedge wr_clk or posedge global_rst) begin
    if (global_rst) begin
      state_r      <= IDLE;
      rr_ptr_r     <= '0;
      grant_id_r   <= '0;
      beat_cnt_r   <= '0;
      burst_done_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          burst_done_r <= 1'b0;
          if (!bus.fifo_prog_full && sel_found_s) begin
            grant_id_r <= sel_id_s;
            beat_cnt_r <= '0;
            state_r    <= BURST;
          end
        end
        BURST: begin
          if (wr_en_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
          end
          if (burst_end_s) begin
            state_r      <= IDLE;
            rr_ptr_r     <= next_ptr_s;
            burst_done_r <= 1'b1;
          end else begin
            burst_done_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          burst_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_s;
  assign bus.fifo_wr_en = wr_en_s;
  assign bus.fifo_din   = din_s;
  assign bus.grant_vld  = (state_r == BURST);
  assign bus.grant_id   = grant_id_r;
  assign bus.burst_done = burst_done_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=64, BURST_LEN=4).
module tb_fifo_wr_arbiter;
  logic wr_clk;
  logic global_rst;
  logic [63:0] chd [4];
  int cmp_cnt;
  int err_cnt;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(64)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(64), .BURST_LEN(4)) dut (
    .wr_clk     (wr_clk),
    .global_rst (global_rst),
    .bus        (bus.master)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) bus.req_data[i*64 +: 64] = chd[i];
  end

  // Source behaviour: a channel moves to its next word after a valid&ready handshake.
  task automatic advance();
    logic [3:0] acc;
    acc = bus.req_valid & bus.req_ready;
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) chd[i] = chd[i] + 64'd1;
  endtask

  task automatic apply_reset();
    global_rst = 1'b1;
    bus.req_valid = 4'b0000;
    bus.fifo_full = 1'b0;
    bus.fifo_prog_full = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1;
    global_rst = 1'b0;
  endtask

  task automatic test_reset();
    global_rst = 1'b1;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge wr_clk);
      cmp_cnt++;
      if (bus.fifo_wr_en !== 1'b0) begin err_cnt++; $display("FAIL reset_wr_en c%0d got %b exp 0", c, bus.fifo_wr_en); end
      cmp_cnt++;
      if (bus.req_ready !== 4'b0000) begin err_cnt++; $display("FAIL reset_ready c%0d got %b exp 0000", c, bus.req_ready); end
      cmp_cnt++;
      if (bus.grant_vld !== 1'b0) begin err_cnt++; $display("FAIL reset_grant_vld c%0d got %b exp 0", c, bus.grant_vld); end
      cmp_cnt++;
      if (bus.burst_done !== 1'b0) begin err_cnt++; $display("FAIL reset_burst_done c%0d got %b exp 0", c, bus.burst_done); end
      cmp_cnt++;
      if (bus.grant_id !== 2'd0) begin err_cnt++; $display("FAIL reset_grant_id c%0d got %0d exp 0", c, bus.grant_id); end
    end
    @(posedge wr_clk);
    #1;
    bus.req_valid = 4'b0000;
    global_rst = 1'b0;
  endtask

  task automatic test_single_channel();
    int  beat;
    logic exp_wr;
    logic exp_done;
    apply_reset();
    chd[2] = 64'h100;
    bus.req_valid = 4'b0100;
    beat = 0;
    for (int c = 0; c < 11; c++) begin
      if (c == 10) bus.req_valid = 4'b0000;
      @(negedge wr_clk);
      exp_wr   = ((c % 5) != 0);
      exp_done = (c == 5) || (c == 10);
      cmp_cnt++;
      if (bus.fifo_wr_en !== exp_wr) begin err_cnt++; $display("FAIL single_wr_en c%0d got %b exp %b", c, bus.fifo_wr_en, exp_wr); end
      cmp_cnt++;
      if (bus.burst_done !== exp_done) begin err_cnt++; $display("FAIL single_burst_done c%0d got %b exp %b", c, bus.burst_done, exp_done); end
      cmp_cnt++;
      if (bus.req_ready !== (exp_wr ? 4'b0100 : 4'b0000)) begin err_cnt++; $display("FAIL single_ready c%0d got %b exp_wr %b", c, bus.req_ready, exp_wr); end
      if (exp_wr) begin
        cmp_cnt++;
        if (bus.grant_id !== 2'd2) begin err_cnt++; $display("FAIL single_grant_id c%0d got %0d exp 2", c, bus.grant_id); end
        cmp_cnt++;
        if (bus.fifo_din !== 64'h100 + 64'(beat)) begin err_cnt++; $display("FAIL single_din c%0d got %h exp %h", c, bus.fifo_din, 64'h100 + 64'(beat)); end
        beat++;
      end
      advance();
    end
  endtask

  task automatic test_fairness();
    int exp_cnt [4];
    int exp_id;
    int pulses;
    logic exp_vld;
    logic [63:0] exp_din;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      chd[i] = 64'(i) << 12;
      exp_cnt[i] = 0;
    end
    bus.req_valid = 4'b1111;
    pulses = 0;
    for (int c = 0; c < 26; c++) begin
      if (c == 25) bus.req_valid = 4'b0000;
      @(negedge wr_clk);
      exp_vld = ((c % 5) != 0);
      exp_id  = (c / 5) % 4;
      if (!exp_vld && c > 0) begin
        cmp_cnt++;
        if (pulses !== 4) begin err_cnt++; $display("FAIL fair_burst_beats c%0d got %0d exp 4", c, pulses); end
        pulses = 0;
      end
      cmp_cnt++;
      if (bus.grant_vld !== exp_vld) begin err_cnt++; $display("FAIL fair_grant_vld c%0d got %b exp %b", c, bus.grant_vld, exp_vld); end
      cmp_cnt++;
      if (bus.fifo_wr_en !== exp_vld) begin err_cnt++; $display("FAIL fair_wr_en c%0d got %b exp %b", c, bus.fifo_wr_en, exp_vld); end
      if (exp_vld) begin
        exp_din = (64'(exp_id) << 12) + 64'(exp_cnt[exp_id]);
        cmp_cnt++;
        if (bus.grant_id !== 2'(exp_id)) begin err_cnt++; $display("FAIL fair_grant_id c%0d got %0d exp %0d", c, bus.grant_id, exp_id); end
        cmp_cnt++;
        if (bus.fifo_din !== exp_din) begin err_cnt++; $display("FAIL fair_din c%0d got %h exp %h", c, bus.fifo_din, exp_din); end
        exp_cnt[exp_id]++;
      end
      if (bus.fifo_wr_en === 1'b1) pulses++;
      advance();
    end
  endtask

  task automatic test_backpressure();
    int beats;
    int acc;
    logic exp_wr;
    logic exp_vld;
    logic exp_done;
    apply_reset();
    chd[0] = 64'hA00;
    bus.req_valid = 4'b0001;
    beats = 0;
    acc = 0;
    for (int c = 0; c < 9; c++) begin
      bus.fifo_full = (c >= 3) && (c <= 5);
      if (c == 8) bus.req_valid = 4'b0000;
      @(negedge wr_clk);
      exp_wr   = (c == 1) || (c == 2) || (c == 6) || (c == 7);
      exp_vld  = (c >= 1) && (c <= 7);
      exp_done = (c == 8);
      cmp_cnt++;
      if (bus.fifo_wr_en !== exp_wr) begin err_cnt++; $display("FAIL bp_wr_en c%0d got %b exp %b", c, bus.fifo_wr_en, exp_wr); end
      cmp_cnt++;
      if (bus.req_ready[0] !== exp_wr) begin err_cnt++; $display("FAIL bp_ready0 c%0d got %b exp %b", c, bus.req_ready[0], exp_wr); end
      cmp_cnt++;
      if (bus.grant_vld !== exp_vld) begin err_cnt++; $display("FAIL bp_grant_vld c%0d got %b exp %b", c, bus.grant_vld, exp_vld); end
      cmp_cnt++;
      if (bus.burst_done !== exp_done) begin err_cnt++; $display("FAIL bp_burst_done c%0d got %b exp %b", c, bus.burst_done, exp_done); end
      if (exp_wr) begin
        cmp_cnt++;
        if (bus.fifo_din !== 64'hA00 + 64'(acc)) begin err_cnt++; $display("FAIL bp_din c%0d got %h exp %h", c, bus.fifo_din, 64'hA00 + 64'(acc)); end
        acc++;
      end
      if (bus.fifo_wr_en === 1'b1) beats++;
      advance();
    end
    cmp_cnt++;
    if (beats !== 4) begin err_cnt++; $display("FAIL bp_total_beats got %0d exp 4", beats); end
  endtask

  task automatic test_early_end_prog_full();
    logic [12:0] vld_t;
    logic [12:0] wr_t;
    logic [12:0] done_t;
    int exp_id;
    logic [63:0] exp_din;
    apply_reset();
    chd[0] = 64'hB00;
    chd[1] = 64'hC00;
    chd[3] = 64'hE00;
    vld_t  = 13'h106E;
    wr_t   = 13'h1026;
    done_t = 13'h0090;
    for (int c = 0; c < 13; c++) begin
      if (c <= 2)      bus.req_valid = 4'b0011;
      else if (c <= 5) bus.req_valid = 4'b0010;
      else if (c <= 7) bus.req_valid = 4'b0000;
      else             bus.req_valid = 4'b1000;
      bus.fifo_prog_full = (c >= 8) && (c <= 10);
      @(negedge wr_clk);
      exp_id  = (c <= 3) ? 0 : ((c <= 6) ? 1 : 3);
      exp_din = (c == 1) ? 64'hB00 : ((c == 2) ? 64'hB01 : ((c == 5) ? 64'hC00 : 64'hE00));
      cmp_cnt++;
      if (bus.grant_vld !== vld_t[c]) begin err_cnt++; $display("FAIL early_grant_vld c%0d got %b exp %b", c, bus.grant_vld, vld_t[c]); end
      cmp_cnt++;
      if (bus.fifo_wr_en !== wr_t[c]) begin err_cnt++; $display("FAIL early_wr_en c%0d got %b exp %b", c, bus.fifo_wr_en, wr_t[c]); end
      cmp_cnt++;
      if (bus.burst_done !== done_t[c]) begin err_cnt++; $display("FAIL early_burst_done c%0d got %b exp %b", c, bus.burst_done, done_t[c]); end
      if (vld_t[c]) begin
        cmp_cnt++;
        if (bus.grant_id !== 2'(exp_id)) begin err_cnt++; $display("FAIL early_grant_id c%0d got %0d exp %0d", c, bus.grant_id, exp_id); end
      end
      if (wr_t[c]) begin
        cmp_cnt++;
        if (bus.fifo_din !== exp_din) begin err_cnt++; $display("FAIL early_din c%0d got %h exp %h", c, bus.fifo_din, exp_din); end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    chd[0] = 64'hF00;
    chd[1] = 64'hD00;
    bus.req_valid = 4'b0010;
    @(negedge wr_clk);
    cmp_cnt++;
    if (bus.grant_vld !== 1'b0) begin err_cnt++; $display("FAIL rmb_idle_vld got %b exp 0", bus.grant_vld); end
    advance();
    @(negedge wr_clk);
    cmp_cnt++;
    if (bus.fifo_wr_en !== 1'b1 || bus.grant_id !== 2'd1 || bus.fifo_din !== 64'hD00) begin
      err_cnt++; $display("FAIL rmb_beat1 got wr %b id %0d din %h exp 1 1 d00", bus.fifo_wr_en, bus.grant_id, bus.fifo_din);
    end
    advance();
    @(negedge wr_clk);
    cmp_cnt++;
    if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 64'hD01) begin
      err_cnt++; $display("FAIL rmb_beat2 got wr %b din %h exp 1 d01", bus.fifo_wr_en, bus.fifo_din);
    end
    #1;
    global_rst = 1'b1;
    #1;
    cmp_cnt++;
    if (bus.fifo_wr_en !== 1'b0) begin err_cnt++; $display("FAIL rmb_async_wr_en got %b exp 0", bus.fifo_wr_en); end
    cmp_cnt++;
    if (bus.req_ready !== 4'b0000) begin err_cnt++; $display("FAIL rmb_async_ready got %b exp 0000", bus.req_ready); end
    cmp_cnt++;
    if (bus.grant_vld !== 1'b0 || bus.grant_id !== 2'd0) begin err_cnt++; $display("FAIL rmb_async_grant got vld %b id %0d exp 0 0", bus.grant_vld, bus.grant_id); end
    bus.req_valid = 4'b1111;
    @(posedge wr_clk);
    #1;
    global_rst = 1'b0;
    @(negedge wr_clk);
    cmp_cnt++;
    if (bus.grant_vld !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin err_cnt++; $display("FAIL rmb_post_idle got vld %b wr %b exp 0 0", bus.grant_vld, bus.fifo_wr_en); end
    advance();
    @(negedge wr_clk);
    cmp_cnt++;
    if (bus.grant_vld !== 1'b1 || bus.grant_id !== 2'd0) begin err_cnt++; $display("FAIL rmb_first_grant got vld %b id %0d exp 1 0", bus.grant_vld, bus.grant_id); end
    cmp_cnt++;
    if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 64'hF00) begin err_cnt++; $display("FAIL rmb_first_beat got wr %b din %h exp 1 f00", bus.fifo_wr_en, bus.fifo_din); end
    advance();
  endtask

  initial begin
    cmp_cnt = 0;
    err_cnt = 0;
    global_rst = 1'b1;
    bus.req_valid = 4'b0000;
    bus.fifo_full = 1'b0;
    bus.fifo_prog_full = 1'b0;
    for (int i = 0; i < 4; i++) chd[i] = 64'h5A5A_0000 + 64'(i);
    test_reset();
    test_single_channel();
    test_fairness();
    test_backpressure();
    test_early_end_prog_full();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
